// File: rtl/sr_32_if.sv
// Bus bundle for the sr_32 serial-in / parallel-out shift register.
// The host side uses the master modport to drive the serial stream and load
// command. The register itself uses the slave modport and returns the held
// word and its status.
interface sr_32_if #(
  parameter int WIDTH = 32
);

  logic             serdata;
  logic             serdata_enable;
  logic             output_enable;
  logic [WIDTH-1:0] parallel_out;
  logic [5:0]       bit_count;
  logic             word_full;

  modport master (
    output serdata,
    output serdata_enable,
    output output_enable,
    input  parallel_out,
    input  bit_count,
    input  word_full
  );

  modport slave (
    input  serdata,
    input  serdata_enable,
    input  output_enable,
    output parallel_out,
    output bit_count,
    output word_full
  );

endinterface

// File: rtl/sr_32.sv
// Serial-in / parallel-out shift register.
// Serial bits arrive MSB-first and are shifted in on enabled edges. A load
// command copies the assembled word into a held parallel register. A status
// counter tracks bits received since reset and saturates at WIDTH.
// Every output comes straight from a flop.
module sr_32 #(
  parameter int WIDTH = 32
) (
  input logic   serdata_clock,
  input logic   serdata_reset,
  sr_32_if.slave bus
);

  // The status counter is 6 bits wide, so it can only express a full word
  // for WIDTH values up to 63.
  localparam logic [5:0] FULL_COUNT = 6'(WIDTH);

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] parallel_reg;
  logic [5:0]       count_reg;
  logic [5:0]       count_next;
  logic             full_reg;

  // Saturating count of enabled shift edges. It holds once it reaches a full word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    count_next = count_reg;
    if (bus.serdata_enable && (count_reg != FULL_COUNT)) begin
      count_next = count_reg + 6'd1;
    end
  end

  // Serial capture: shift MSB-first and update the status counter and full flag.
  always_ff @(posedge serdata_clock or posedge serdata_reset) begin
    if (serdata_reset) begin
      shift_reg <= '0;
      count_reg <= '0;
      full_reg  <= 1'b0;
    end else begin
      if (bus.serdata_enable) begin
        shift_reg <= {shift_reg[WIDTH-2:0], bus.serdata};
      end
      count_reg <= count_next;
      full_reg  <= (count_next == FULL_COUNT);
    end
  end

  // Parallel load: copy the shift register on command, and hold it otherwise.
  always_ff @(posedge serdata_clock or posedge serdata_reset) begin
    if (serdata_reset) begin
      parallel_reg <= '0;
    end else if (bus.output_enable) begin
      // NOTE: non-blocking assignment means this reads shift_reg as it was before
      // this edge, so a shift and a load on the same edge capture the pre-shift word.
      parallel_reg <= shift_reg;
    end
  end

  assign bus.parallel_out = parallel_reg;
  assign bus.bit_count    = count_reg;
  assign bus.word_full    = full_reg;

endmodule

// File: tb/tb_sr_32.sv
// Directed testbench for sr_32.
// It runs hand-written sequences for reset, hold, async reset, overflow and
// same-edge shift/load, followed by a table of shift/load vectors whose
// expected results were computed by hand.
module tb_sr_32;

  logic clk;
  logic rst;
  logic clk_run;

  int checks;
  int errors;

  sr_32_if #(.WIDTH(32)) bus ();

  sr_32 #(.WIDTH(32)) dut (
    .serdata_clock (clk),
    .serdata_reset (rst),
    .bus           (bus.slave)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  typedef struct {
    logic        do_reset;
    logic [31:0] word;
    int          nbits;
    logic        do_load;
    logic [31:0] exp_out;
    logic [5:0]  exp_count;
    logic        exp_full;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_word(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.serdata        = w[i];
      bus.serdata_enable = 1'b1;
      tick();
    end
    bus.serdata_enable = 1'b0;
    bus.serdata        = 1'b0;
  endtask

  task automatic load_word();
    bus.output_enable = 1'b1;
    tick();
    bus.output_enable = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic [31:0] out,
                              input logic [5:0] cnt, input logic full);
    check({tag, " parallel_out"}, bus.parallel_out, out);
    check({tag, " bit_count"}, 32'(bus.bit_count), 32'(cnt));
    check({tag, " word_full"}, 32'(bus.word_full), 32'(full));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    clk_run = 1'b0;
    rst     = 1'b0;
    bus.serdata        = 1'b0;
    bus.serdata_enable = 1'b0;
    bus.output_enable  = 1'b0;

    vecs[0] = '{1'b1, 32'h0000_7D00, 32, 1'b1, 32'h0000_7D00, 6'd32, 1'b1};
    vecs[1] = '{1'b1, 32'h0000_00A5,  8, 1'b1, 32'h0000_00A5, 6'd8,  1'b0};
    vecs[2] = '{1'b0, 32'h0000_0003,  2, 1'b1, 32'h0000_0297, 6'd10, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0000,  0, 1'b0, 32'h0000_0297, 6'd10, 1'b0};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 31, 1'b1, 32'h7FFF_FFFF, 6'd31, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0001,  1, 1'b1, 32'hFFFF_FFFF, 6'd32, 1'b1};
    vecs[6] = '{1'b0, 32'h0000_0000,  4, 1'b1, 32'hFFFF_FFF0, 6'd32, 1'b1};

    // Reset with the clock stopped: outputs must clear without any edge.
    #3;
    rst = 1'b1;
    #2;
    check_status("reset_noclk", 32'h0, 6'd0, 1'b0);
    rst = 1'b0;
    #2;
    clk_run = 1'b1;
    tick();

    // Full word, then load. The result appears one edge after output_enable.
    shift_word(32'h0000_7D00, 32);
    check("pre_load parallel_out", bus.parallel_out, 32'h0);
    load_word();
    check_status("word_7d00", 32'h0000_7D00, 6'd32, 1'b1);

    // Dropping output_enable holds the word, and re-raising it reloads the same word.
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_%0d parallel_out", i), bus.parallel_out, 32'h0000_7D00);
    end
    load_word();
    check("reload parallel_out", bus.parallel_out, 32'h0000_7D00);

    // Shift and load on the same edge: the load sees the pre-shift word.
    bus.serdata        = 1'b1;
    bus.serdata_enable = 1'b1;
    bus.output_enable  = 1'b1;
    tick();
    bus.serdata_enable = 1'b0;
    bus.serdata        = 1'b0;
    check_status("same_edge", 32'h0000_7D00, 6'd32, 1'b1);
    tick();
    bus.output_enable = 1'b0;
    check("post_shift parallel_out", bus.parallel_out, 32'h0000_FA01);

    // Async reset while output_enable is high, then a new word loaded later.
    bus.output_enable = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_status("async_rst", 32'h0, 6'd0, 1'b0);
    tick();
    tick();
    check("rst_held parallel_out", bus.parallel_out, 32'h0);
    rst = 1'b0;
    bus.output_enable = 1'b0;
    tick();
    shift_word(32'h0000_EA60, 32);
    check_status("ea60_unloaded", 32'h0, 6'd32, 1'b1);
    load_word();
    check("ea60 parallel_out", bus.parallel_out, 32'h0000_EA60);

    // 33 bits in: the first bit drops off the MSB and the count saturates.
    pulse_reset();
    tick();
    shift_word(32'h1, 1);
    shift_word(32'h0000_0005, 32);
    load_word();
    check_status("overflow33", 32'h0000_0005, 6'd32, 1'b1);

    // Table-driven vectors.
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].do_reset) begin
        pulse_reset();
        tick();
      end
      shift_word(vecs[v].word, vecs[v].nbits);
      if (vecs[v].do_load) load_word();
      else tick();
      check_status($sformatf("vec%0d", v), vecs[v].exp_out, vecs[v].exp_count,
                   vecs[v].exp_full);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
